// File: rtl/sccb_reg_sequencer.sv
// Turns one register read/write request into the SCCB controller command
// sequence (START / WRITE / READ / STOP), with a per-step cycle timeout.
module sccb_reg_sequencer #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_wr,
  input  logic [7:0] req_id,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdat,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdat,
  output logic       ctl_flag,
  output logic [3:0] ctl_cmd,
  output logic [7:0] ctl_dat,
  input  logic       ctl_busy,
  input  logic [7:0] ctl_rdat,
  input  logic       ctl_rflag
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  localparam logic [3:0] CMD_IDLE  = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0011;
  localparam logic [3:0] CMD_STOP  = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_NEXT, S_RESP
  } state_t;

  state_t        state;
  logic [2:0]    step;
  logic [CW-1:0] cyc;
  logic          wr_q;
  logic [7:0]    id_q, addr_q, wdat_q;
  logic          busy_seen;
  logic          rd_got;

  logic [CW-1:0] cyc_nxt;
  logic          in_step;
  logic          to_hit;
  logic          rd_step;
  logic          rd_cap;
  logic [2:0]    last_step;

  // {cmd, dat} for a given step of a write or read transaction
  function automatic logic [11:0] step_word(input logic wr, input logic [2:0] s,
                                            input logic [7:0] id, input logic [7:0] addr,
                                            input logic [7:0] wdat);
    logic [11:0] w;
    if (wr) begin
      case (s)
        3'd0:    w = {CMD_START, 8'h00};
        3'd1:    w = {CMD_WRITE, id[7:1], 1'b0};
        3'd2:    w = {CMD_WRITE, addr};
        3'd3:    w = {CMD_WRITE, wdat};
        default: w = {CMD_STOP, 8'h00};
      endcase
    end else begin
      case (s)
        3'd0:    w = {CMD_START, 8'h00};
        3'd1:    w = {CMD_WRITE, id[7:1], 1'b0};
        3'd2:    w = {CMD_WRITE, addr};
        3'd3:    w = {CMD_STOP, 8'h00};
        3'd4:    w = {CMD_START, 8'h00};
        3'd5:    w = {CMD_WRITE, id[7:1], 1'b1};
        3'd6:    w = {CMD_READ, 8'h00};
        default: w = {CMD_STOP, 8'h00};
      endcase
    end
    return w;
  endfunction

  assign cyc_nxt   = cyc + 1'b1;
  assign in_step   = (state == S_ISSUE) || (state == S_WAIT_ACC) || (state == S_WAIT_DONE);
  assign to_hit    = in_step && (cyc_nxt == TO_VAL);
  assign rd_step   = (ctl_cmd == CMD_READ);
  assign last_step = wr_q ? 3'd4 : 3'd7;
  // first rflag wins; otherwise take whatever the controller presents when it goes idle
  assign rd_cap    = in_step && rd_step && !rd_got &&
                     (ctl_rflag || ((state == S_WAIT_DONE) && !ctl_busy));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      step      <= 3'd0;
      cyc       <= '0;
      wr_q      <= 1'b0;
      id_q      <= 8'h00;
      addr_q    <= 8'h00;
      wdat_q    <= 8'h00;
      busy_seen <= 1'b0;
      rd_got    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdat  <= 8'h00;
      ctl_flag  <= 1'b0;
      ctl_cmd   <= CMD_IDLE;
      ctl_dat   <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ctl_flag  <= 1'b0;

      if (rd_cap) begin
        rsp_rdat <= ctl_rdat;
        rd_got   <= 1'b1;
      end

      if (to_hit) begin
        // abandon the transaction outright; no STOP is attempted
        ctl_cmd   <= CMD_IDLE;
        ctl_dat   <= 8'h00;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        state     <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (req && req_ready) begin
              wr_q               <= req_wr;
              id_q               <= req_id;
              addr_q             <= req_addr;
              wdat_q             <= req_wdat;
              step               <= 3'd0;
              {ctl_cmd, ctl_dat} <= step_word(req_wr, 3'd0, req_id, req_addr, req_wdat);
              cyc                <= '0;
              busy_seen          <= 1'b0;
              rd_got             <= 1'b0;
              req_ready          <= 1'b0;
              state              <= S_LOAD;
            end else begin
              req_ready <= 1'b1;
            end
          end
          S_LOAD: begin
            if (!ctl_busy) begin
              ctl_flag <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            cyc <= cyc_nxt;
            // a busy blip fully inside this cycle still counts as acceptance
            if (ctl_busy) busy_seen <= 1'b1;
            state <= S_WAIT_ACC;
          end
          S_WAIT_ACC: begin
            cyc <= cyc_nxt;
            if (ctl_busy || busy_seen) state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            cyc <= cyc_nxt;
            if (!ctl_busy) state <= S_NEXT;
          end
          S_NEXT: begin
            step <= step + 3'd1;
            if (step == last_step) begin
              ctl_cmd   <= CMD_IDLE;
              ctl_dat   <= 8'h00;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              {ctl_cmd, ctl_dat} <= step_word(wr_q, step + 3'd1, id_q, addr_q, wdat_q);
              cyc                <= '0;
              busy_seen          <= 1'b0;
              rd_got             <= 1'b0;
              state              <= S_LOAD;
            end
          end
          S_RESP: begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Directed bench for sccb_reg_sequencer with a small SCCB controller model.
module tb_sccb_reg_sequencer;

  logic       sys_clk;
  logic       rst;
  logic       req, req_wr;
  logic [7:0] req_id, req_addr, req_wdat;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdat;
  logic       ctl_flag;
  logic [3:0] ctl_cmd;
  logic [7:0] ctl_dat;
  logic       ctl_busy;
  logic [7:0] ctl_rdat;
  logic       ctl_rflag;

  sccb_reg_sequencer #(.TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req(req), .req_wr(req_wr), .req_id(req_id), .req_addr(req_addr), .req_wdat(req_wdat),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdat(rsp_rdat),
    .ctl_flag(ctl_flag), .ctl_cmd(ctl_cmd), .ctl_dat(ctl_dat),
    .ctl_busy(ctl_busy), .ctl_rdat(ctl_rdat), .ctl_rflag(ctl_rflag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  // controller model knobs (written only by the main initial block)
  int         mode = 0;      // 0 normal, 1 busy blip in ISSUE, 2 no rflag (static rdat)
  logic       dead = 1'b0;   // never raises busy
  logic       hold = 1'b0;   // force busy high
  logic [7:0] rd_val = 8'h00;

  // controller model state (written only by the model)
  int         bcnt = 0;
  logic       busy_i = 1'b0;
  logic       rd_pend = 1'b0;
  int         nflag = 0;
  int         cyc_n = 0;
  int         flag_cyc = 0;
  logic [3:0] log_cmd [128];
  logic [7:0] log_dat [128];

  always @(negedge sys_clk) begin
    cyc_n     = cyc_n + 1;
    ctl_rflag = 1'b0;
    ctl_rdat  = (mode == 2) ? rd_val : 8'hEE;
    if (!rst) begin
      bcnt    = 0;
      busy_i  = 1'b0;
      rd_pend = 1'b0;
    end else begin
      if (bcnt > 0) begin
        bcnt   = bcnt - 1;
        busy_i = (bcnt != 0);
        if (bcnt == 1 && rd_pend && mode != 2) begin
          ctl_rflag = 1'b1;
          ctl_rdat  = rd_val;
          rd_pend   = 1'b0;
        end
      end
      if (ctl_flag) begin
        if (nflag < 128) begin
          log_cmd[nflag] = ctl_cmd;
          log_dat[nflag] = ctl_dat;
        end
        nflag    = nflag + 1;
        flag_cyc = cyc_n;
        rd_pend  = (ctl_cmd == 4'h3);
        if (!dead) begin
          if (mode == 1) begin
            busy_i = 1'b1;
            bcnt   = 1;
          end else begin
            bcnt = 3;
          end
        end
      end
    end
    ctl_busy = hold | busy_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [7:0] id, input logic [7:0] addr,
                          input logic [7:0] wdat);
    int w;
    w = 0;
    step();
    while (!req_ready && w < 100) begin
      step();
      w++;
    end
    req = 1'b1; req_wr = wr; req_id = id; req_addr = addr; req_wdat = wdat;
    step();
    req = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic err, output logic [7:0] rdat,
                          output logic [3:0] cmd, output int at);
    got = 1'b0; err = 1'b0; rdat = 8'h00; cmd = 4'hF; at = 0;
    for (int c = 0; c < 400; c++) begin
      if (rsp_valid) begin
        got = 1'b1; err = rsp_err; rdat = rsp_rdat; cmd = ctl_cmd; at = cyc_n;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic            wr;
    logic [7:0]      id, addr, wdat;
    int              mode;
    logic [7:0]      rd_val;
    int              n;
    logic [7:0][3:0] cmd;
    logic [7:0][7:0] dat;
    logic [7:0]      exp_rdat;
  } vec_t;

  vec_t vec [4];

  initial begin
    logic       got, err;
    logic [7:0] rdat;
    logic [3:0] rcmd;
    int         at, base, w;

    // element 0 of each packed list is the first step
    vec[0] = '{1'b1, 8'h43, 8'h12, 8'h80, 0, 8'h00, 5,
               {4'h6, 4'h2, 4'h2, 4'h2, 4'h1},
               {8'h00, 8'h80, 8'h12, 8'h42, 8'h00}, 8'h00};
    vec[1] = '{1'b0, 8'h42, 8'h0A, 8'h00, 0, 8'h76, 8,
               {4'h6, 4'h3, 4'h2, 4'h1, 4'h6, 4'h2, 4'h2, 4'h1},
               {8'h00, 8'h00, 8'h43, 8'h00, 8'h00, 8'h0A, 8'h42, 8'h00}, 8'h76};
    vec[2] = '{1'b1, 8'h61, 8'h3C, 8'hFF, 1, 8'h00, 5,
               {4'h6, 4'h2, 4'h2, 4'h2, 4'h1},
               {8'h00, 8'hFF, 8'h3C, 8'h60, 8'h00}, 8'h76};
    vec[3] = '{1'b0, 8'h21, 8'h55, 8'h00, 2, 8'h5C, 8,
               {4'h6, 4'h3, 4'h2, 4'h1, 4'h6, 4'h2, 4'h2, 4'h1},
               {8'h00, 8'h00, 8'h21, 8'h00, 8'h00, 8'h55, 8'h20, 8'h00}, 8'h5C};

    rst = 1'b0; req = 1'b0; req_wr = 1'b0; req_id = 8'h00; req_addr = 8'h00; req_wdat = 8'h00;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err",   rsp_err, 0);
    chk("rst_rsp_rdat",  rsp_rdat, 0);
    chk("rst_ctl_flag",  ctl_flag, 0);
    chk("rst_ctl_cmd",   ctl_cmd, 0);
    chk("rst_ctl_dat",   ctl_dat, 0);
    rst = 1'b1;
    step();
    chk("rel_req_ready", req_ready, 1);

    for (int i = 0; i < 4; i++) begin
      mode   = vec[i].mode;
      rd_val = vec[i].rd_val;
      base   = nflag;
      send_req(vec[i].wr, vec[i].id, vec[i].addr, vec[i].wdat);
      wait_rsp(got, err, rdat, rcmd, at);
      chk($sformatf("v%0d_rsp_seen", i), got, 1);
      chk($sformatf("v%0d_rsp_err", i), err, 0);
      chk($sformatf("v%0d_rsp_rdat", i), rdat, vec[i].exp_rdat);
      chk($sformatf("v%0d_flags", i), nflag - base, vec[i].n);
      for (int s = 0; s < vec[i].n; s++) begin
        chk($sformatf("v%0d_cmd%0d", i, s), log_cmd[base + s], vec[i].cmd[s]);
        chk($sformatf("v%0d_dat%0d", i, s), log_dat[base + s], vec[i].dat[s]);
      end
      step();
      chk($sformatf("v%0d_ready_after", i), req_ready, 1);
    end
    mode = 0;

    // busy held high across the first LOAD
    hold = 1'b1;
    step();
    base = nflag;
    send_req(1'b1, 8'h43, 8'h12, 8'h80);
    repeat (20) step();
    chk("hold_no_flag", nflag - base, 0);
    chk("hold_cmd_stable", ctl_cmd, 4'h1);
    hold = 1'b0;
    repeat (3) step();
    chk("hold_one_flag", nflag - base, 1);
    wait_rsp(got, err, rdat, rcmd, at);
    chk("hold_rsp_seen", got, 1);
    chk("hold_rsp_err", err, 0);
    chk("hold_flags", nflag - base, 5);

    // controller never acknowledges
    dead = 1'b1;
    step();
    base = nflag;
    send_req(1'b1, 8'h43, 8'h12, 8'h80);
    wait_rsp(got, err, rdat, rcmd, at);
    chk("to_rsp_seen", got, 1);
    chk("to_rsp_err", err, 1);
    chk("to_cmd_idle", rcmd, 0);
    chk("to_latency", at - flag_cyc, 16);
    repeat (10) step();
    chk("to_no_more_flags", nflag - base, 1);
    dead = 1'b0;

    // stray req mid-transaction, then reset during WAIT_DONE of a read
    rd_val = 8'h99;
    base = nflag;
    send_req(1'b0, 8'h42, 8'h0A, 8'h00);
    step();
    req = 1'b1; req_wr = 1'b1; req_id = 8'hF0; req_addr = 8'hBB; req_wdat = 8'h11;
    step();
    req = 1'b0;
    w = 0;
    while (nflag - base < 3 && w < 100) begin
      step();
      w++;
    end
    chk("mr_reached_step2", (nflag - base >= 3) ? 1 : 0, 1);
    step();
    step();
    chk("mr_log_cmd0", log_cmd[base], 4'h1);
    chk("mr_log_dat1", log_dat[base + 1], 8'h42);
    chk("mr_log_dat2", log_dat[base + 2], 8'h0A);
    chk("mr_busy_pre", ctl_busy, 1);
    chk("mr_dat_pre", ctl_dat, 8'h0A);
    rst = 1'b0;
    #1;
    chk("mr_req_ready", req_ready, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_err",   rsp_err, 0);
    chk("mr_rsp_rdat",  rsp_rdat, 0);
    chk("mr_ctl_flag",  ctl_flag, 0);
    chk("mr_ctl_cmd",   ctl_cmd, 0);
    chk("mr_ctl_dat",   ctl_dat, 0);
    repeat (3) step();
    chk("mr_ready_held", req_ready, 0);
    rst = 1'b1;
    step();
    chk("mr_ready_release", req_ready, 1);
    repeat (10) step();
    chk("mr_no_activity", nflag - base, 3);
    chk("mr_no_rsp", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
